// File: rtl/bin2seg_pkg.sv
// Shared types and constants for the sequential binary-to-7-segment converter.
package bin2seg_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // Active-high patterns, bit order g..a
  localparam logic [6:0] SEG_LUT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// One BCD digit to 7-segment pattern, with dash/blank override and polarity select.
module seg7_encode
  import bin2seg_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       dash,
  input  logic       act_low,
  output logic [6:0] seg
);

  logic [6:0] pat;

  always_comb begin
    pat = SEG_BLANK;
    if (dash)
      pat = SEG_DASH;
    else if (!blank && digit < 4'd10)
      pat = SEG_LUT[digit];
    seg = act_low ? ~pat : pat;
  end

endmodule

// File: rtl/bin2seg_seq.sv
// Iterative double-dabble converter: one input bit per clock, registered BCD,
// 7-segment patterns with leading-zero blanking and overflow dashes.
module bin2seg_seq
  import bin2seg_pkg::*;
#(
  parameter int IN_W        = 14,
  parameter int DIGITS      = 5,
  parameter int BLANK_LZ    = 1,
  parameter int SEG_ACT_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_data,
  output logic                  busy,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  overflow
);

  localparam int         CNT_W   = (IN_W > 1) ? clog2(IN_W) : 1;
  localparam logic [6:0] SEG_OFF = (SEG_ACT_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;

  state_t                   state, state_nxt;
  logic [IN_W-1:0]          shreg;
  logic [DIGITS-1:0][3:0]   scr, scr_adj;
  logic [CNT_W-1:0]         cnt;
  logic                     ovf_st;
  logic [DIGITS-1:0]        blank;
  logic [DIGITS-1:0][6:0]   seg_nxt;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    for (int k = 0; k < DIGITS; k++)
      scr_adj[k] = (scr[k] >= 4'd5) ? scr[k] + 4'd3 : scr[k];
  end

  // A digit is blanked only if it and every digit above it are zero
  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    if (k == 0) begin : g_units
      assign blank[k] = 1'b0;
    end else begin : g_upper
      assign blank[k] = (BLANK_LZ != 0) && (scr[DIGITS-1:k] == '0);
    end
    seg7_encode u_enc (
      .digit   (scr[k]),
      .blank   (blank[k]),
      .dash    (ovf_st),
      .act_low (SEG_ACT_LOW != 0),
      .seg     (seg_nxt[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shreg     <= '0;
      scr       <= '0;
      cnt       <= '0;
      ovf_st    <= 1'b0;
      bcd       <= '0;
      seg       <= {DIGITS{SEG_OFF}};
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          shreg  <= in_data;
          scr    <= '0;
          ovf_st <= 1'b0;
          cnt    <= CNT_W'(IN_W - 1);
        end
        SHIFT: begin
          {scr, shreg} <= {scr_adj, shreg} << 1;
          if (scr_adj[DIGITS-1][3]) ovf_st <= 1'b1;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        DONE: begin
          bcd       <= scr;
          seg       <= seg_nxt;
          overflow  <= ovf_st;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
